dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port, 256x16 data memory between the CPU control unit and a debug/program-loader port. The CPU issues accesses from its Store and Load states. The debug port preloads and inspects memory while the CPU runs or is halted. The block sits between both requesters and the RAM, which has a 1-cycle read latency. It grants one access per cycle, stalls whichever requester loses, bounds debug starvation and supports a locked debug burst.

## Interface
Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 16, memory data width
- STARVE_LIMIT, 4, consecutive denied debug-request cycles before debug is forced priority (range 1..15)

Ports:
- Clk  in  1  system clock, all state updates on posedge
- ResetN  in  1  synchronous, active-low reset
- cpu_req  in  1  CPU requests an access this cycle
- cpu_wr  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access performed this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt; control unit holds its state
- cpu_rvalid  out  1  rdata holds the CPU read granted last cycle
- dbg_req, dbg_wr, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug request, same meaning as CPU fields
- dbg_lock  in  1  hold the memory for a debug burst
- dbg_gnt  out  1  debug access performed this cycle
- dbg_rvalid  out  1  rdata holds the debug read granted last cycle
- rdata  out  DATA_W  read data, equals mem_rdata
- mem_addr, mem_wdata  out  ADDR_W/DATA_W  RAM address and write data
- mem_wr  out  1  RAM write enable
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after the address

## Operation
- Arbiter state arb_state_t: PRI_CPU, PRI_DBG, DBG_LOCK. Reset state is PRI_CPU.
- Grants are combinational from the requests and the state. At most one grant per cycle.
- PRI_CPU: CPU wins a simultaneous request. Debug is granted only when cpu_req = 0.
- PRI_DBG: debug wins a simultaneous request. After any debug grant, return to PRI_CPU.
- DBG_LOCK: only debug may be granted; cpu_gnt = 0. Exit to PRI_CPU on the posedge where dbg_lock = 0.
- Entry to DBG_LOCK: from any state, when dbg_gnt = 1 and dbg_lock = 1.
- Starvation counter (4 bits):
  - Increments, saturating at STARVE_LIMIT, on each cycle with dbg_req & ~dbg_gnt.
  - Clears on dbg_gnt or when dbg_req = 0.
  - PRI_CPU moves to PRI_DBG when the counter reaches STARVE_LIMIT.
- Memory mux:
  - Granted requester's addr and wdata drive mem_addr and mem_wdata.
  - mem_wr = granted wr.
  - No grant: mem_addr and mem_wdata = 0, mem_wr = 0.
- Read-valid flops:
  - cpu_rvalid <= cpu_gnt & ~cpu_wr.
  - dbg_rvalid <= dbg_gnt & ~dbg_wr.
  - rdata is mem_rdata unregistered.
- A request with no grant is not remembered. The requester holds its request until granted.

## Timing
- Grant latency: 0 cycles. The write commits at the posedge ending the grant cycle.
- Read latency: data and rvalid appear in the cycle after the grant.
- Back-to-back grants are allowed every cycle, including alternating owners. Read data of one owner coexists with the grant of the other.
- While ResetN = 0:
  - cpu_gnt, dbg_gnt and mem_wr are forced to 0 combinationally.
  - cpu_stall = cpu_req.
  - On the posedge: state <= PRI_CPU, counter <= 0, cpu_rvalid and dbg_rvalid <= 0.
- Reset during a read: the pending rvalid is dropped. Reset during DBG_LOCK: lock is released.
- dbg_lock with dbg_req = 0 has no effect outside DBG_LOCK.
- Inside DBG_LOCK with dbg_req = 0 and dbg_lock = 1: no grants, lock held.

## Structure
- Package dmem_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_t {PRI_CPU, PRI_DBG, DBG_LOCK}
  - localparams DMEM_ADDR_W = 8, DMEM_DATA_W = 16
  - function arb_state_to_string for benches
- Sub-module arb_starve_counter: saturating counter with inc/clr/limit inputs and an at_limit output.
- Top module holds the FSM, grant logic, mux and rvalid flops.

## Test plan
- Reset: ResetN = 0 for 2 cycles with both requests high -> gnts 0, mem_wr 0, cpu_stall 1. After release, state PRI_CPU and rvalids 0.
- CPU write then read:
  - Write cpu_addr 8'h10, data 16'hBEEF -> cpu_gnt 1, mem_wr 1 in the same cycle.
  - Next cycle, read 8'h10 -> the following cycle cpu_rvalid 1 and rdata 16'hBEEF.
- Contention, STARVE_LIMIT = 4: both request continuously -> CPU is granted 4 cycles, debug 1, then CPU again. cpu_stall is 1 exactly on the debug-grant cycle.
- Lock burst:
  - Debug writes 8'h00..8'h03 with dbg_lock 1 while cpu_req = 1 -> dbg_gnt 1 for 4 cycles, cpu_gnt 0.
  - Drop dbg_lock on the last write -> CPU is granted the next cycle.
- Mixed reads: CPU reads 8'h20 in cycle n, debug reads 8'h21 in cycle n+1 -> cpu_rvalid in n+1 and dbg_rvalid in n+2, each with the correct rdata and never both valid at once.
- Reset mid-lock: assert ResetN = 0 during DBG_LOCK with a debug read pending -> the next cycle has dbg_rvalid 0 and state PRI_CPU.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the data-memory arbiter between the CPU and the debug port.
package dmem_arb_pkg;

  localparam int unsigned DMEM_ADDR_W  = 8;
  localparam int unsigned DMEM_DATA_W  = 16;
  localparam int unsigned STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    PRI_CPU  = 2'd0,
    PRI_DBG  = 2'd1,
    DBG_LOCK = 2'd2
  } arb_state_t;

  function automatic string arb_state_to_string(input arb_state_t s);
    case (s)
      PRI_CPU:  return "PRI_CPU";
      PRI_DBG:  return "PRI_DBG";
      DBG_LOCK: return "DBG_LOCK";
      default:  return "UNKNOWN";
    endcase
  endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive denied debug-request cycles.
module arb_starve_counter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned CNT_W = STARVE_CNT_W
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             inc,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic             at_limit
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q < limit)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Looks at the post-update value so priority flips on the edge the limit is reached.
  assign at_limit = (cnt_d == limit);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU vs debug port, starvation bound and locked debug bursts.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = DMEM_ADDR_W,
  parameter int unsigned DATA_W       = DMEM_DATA_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  input  logic              dbg_req,
  input  logic              dbg_wr,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = STARVE_CNT_W;

  arb_state_t state_q;
  arb_state_t state_d;
  logic       at_limit;
  logic       starve_inc;
  logic       starve_clr;

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state_q <= PRI_CPU;
    end else begin
      state_q <= state_d;
    end
  end

  // Lock entry takes precedence over every other transition.
  always_comb begin
    state_d = state_q;
    if (dbg_gnt && dbg_lock) begin
      state_d = DBG_LOCK;
    end else begin
      case (state_q)
        PRI_CPU:  if (at_limit) state_d = PRI_DBG;
        PRI_DBG:  if (dbg_gnt) state_d = PRI_CPU;
        DBG_LOCK: if (!dbg_lock) state_d = PRI_CPU;
        default:  state_d = PRI_CPU;
      endcase
    end
  end

  // Grants are combinational and suppressed while reset is held.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (ResetN) begin
      case (state_q)
        PRI_CPU: begin
          cpu_gnt = cpu_req;
          dbg_gnt = dbg_req & ~cpu_req;
        end
        PRI_DBG: begin
          dbg_gnt = dbg_req;
          cpu_gnt = cpu_req & ~dbg_req;
        end
        DBG_LOCK: begin
          dbg_gnt = dbg_req;
        end
        default: begin
        end
      endcase
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  assign starve_inc = dbg_req & ~dbg_gnt;
  assign starve_clr = dbg_gnt | ~dbg_req;

  arb_starve_counter #(
    .CNT_W (CNT_W)
  ) u_starve (
    .Clk      (Clk),
    .ResetN   (ResetN),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .limit    (CNT_W'(STARVE_LIMIT)),
    .at_limit (at_limit)
  );

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wr    = 1'b0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wr    = cpu_wr;
    end else if (dbg_gnt) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_wr    = dbg_wr;
    end
  end

  // RAM answers one cycle after the address, so the owner tag is delayed to match.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_gnt & ~cpu_wr;
      dbg_rvalid <= dbg_gnt & ~dbg_wr;
    end
  end

  assign rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural RAM and a read-return scoreboard.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  logic          Clk = 1'b0;
  logic          ResetN;
  logic          cpu_req, cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_stall, cpu_rvalid;
  logic          dbg_req, dbg_wr, dbg_lock;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt, dbg_rvalid;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_wr;

  logic [DW-1:0] ram     [256];
  logic [DW-1:0] ref_mem [256];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    bit          is_cpu;
    logic [DW-1:0] data;
    int          due;
  } rd_t;
  rd_t sbq[$];

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
    .Clk        (Clk),
    .ResetN     (ResetN),
    .cpu_req    (cpu_req),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .dbg_req    (dbg_req),
    .dbg_wr     (dbg_wr),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_lock   (dbg_lock),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .rdata      (rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wr     (mem_wr),
    .mem_rdata  (mem_rdata)
  );

  always #5 Clk = ~Clk;

  // 256x16 RAM with one-cycle read latency
  always @(posedge Clk) begin
    if (mem_wr) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input arb_state_t exp);
    checks++;
    assert (dut.state_q === exp) else begin
      errors++;
      $error("FAIL %s: observed %s expected %s", tag,
             arb_state_to_string(dut.state_q), arb_state_to_string(exp));
    end
  endtask

  task automatic set_cpu(input logic req, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    cpu_req = req; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dbg(input logic req, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic lock);
    dbg_req = req; dbg_wr = wr; dbg_addr = a; dbg_wdata = d; dbg_lock = lock;
  endtask

  // Called at a negedge with inputs already driven; checks this cycle, then advances one cycle.
  task automatic step(input string tag, input logic exp_c, input logic exp_d);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ew;
    logic          is_rd;
    rd_t           e;
    #1;
    ea = '0; ed = '0; ew = 1'b0; is_rd = 1'b0;
    if (exp_c) begin
      ea = cpu_addr; ed = cpu_wdata; ew = cpu_wr; is_rd = ~cpu_wr;
    end else if (exp_d) begin
      ea = dbg_addr; ed = dbg_wdata; ew = dbg_wr; is_rd = ~dbg_wr;
    end
    chk({tag, " cpu_gnt"},   32'(cpu_gnt),   32'(exp_c));
    chk({tag, " dbg_gnt"},   32'(dbg_gnt),   32'(exp_d));
    chk({tag, " cpu_stall"}, 32'(cpu_stall), 32'(cpu_req & ~exp_c));
    chk({tag, " mem_wr"},    32'(mem_wr),    32'(ew));
    chk({tag, " mem_addr"},  32'(mem_addr),  32'(ea));
    chk({tag, " mem_wdata"}, 32'(mem_wdata), 32'(ed));
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      chk({tag, " rvalid"}, 32'({cpu_rvalid, dbg_rvalid}), 32'({e.is_cpu, ~e.is_cpu}));
      chk({tag, " rdata"},  32'(rdata), 32'(e.data));
    end else begin
      chk({tag, " rvalid"}, 32'({cpu_rvalid, dbg_rvalid}), 32'(0));
    end
    if (is_rd) sbq.push_back('{exp_c, ref_mem[ea], cyc + 1});
    if (ew) ref_mem[ea] = ed;
    cyc++;
    @(negedge Clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ResetN = 1'b0;
    set_cpu(1'b1, 1'b0, 8'h00, 16'h0000);
    set_dbg(1'b1, 1'b0, 8'h00, 16'h0000, 1'b0);
    @(negedge Clk);

    // Reset with both requesting
    step("rst0", 1'b0, 1'b0);
    step("rst1", 1'b0, 1'b0);
    ResetN = 1'b1;
    set_cpu(1'b0, 1'b0, 8'h00, 16'h0000);
    set_dbg(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    chk_state("post_rst state", PRI_CPU);
    step("idle0", 1'b0, 1'b0);

    // CPU write then read back
    set_cpu(1'b1, 1'b1, 8'h10, 16'hBEEF); step("cpu_wr", 1'b1, 1'b0);
    set_cpu(1'b1, 1'b0, 8'h10, 16'h0000); step("cpu_rd", 1'b1, 1'b0);
    set_cpu(1'b0, 1'b0, 8'h00, 16'h0000); step("cpu_rd_ret", 1'b0, 1'b0);

    // Continuous contention: four CPU grants, then one debug grant
    for (int i = 0; i < 10; i++) begin
      set_cpu(1'b1, 1'b1, 8'h30, 16'(16'h0100 + i));
      set_dbg(1'b1, 1'b1, 8'h31, 16'(16'h0200 + i), 1'b0);
      step("contend", 1'((i % 5) != 4), 1'((i % 5) == 4));
    end
    set_cpu(1'b0, 1'b0, 8'h00, 16'h0000);
    set_dbg(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    step("idle1", 1'b0, 1'b0);

    // Locked debug burst with the CPU held off
    set_dbg(1'b1, 1'b1, 8'h00, 16'hA000, 1'b1); step("lock0", 1'b0, 1'b1);
    chk_state("lock entered", DBG_LOCK);
    set_cpu(1'b1, 1'b1, 8'h40, 16'hC0DE);
    set_dbg(1'b1, 1'b1, 8'h01, 16'hA001, 1'b1); step("lock1", 1'b0, 1'b1);
    set_dbg(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1); step("lock_hold", 1'b0, 1'b0);
    chk_state("lock held", DBG_LOCK);
    set_dbg(1'b1, 1'b1, 8'h02, 16'hA002, 1'b1); step("lock2", 1'b0, 1'b1);
    set_dbg(1'b1, 1'b1, 8'h03, 16'hA003, 1'b0); step("lock3", 1'b0, 1'b1);
    set_dbg(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0); step("lock_exit", 1'b1, 1'b0);

    // Mixed reads from both owners, including alternating grants
    set_cpu(1'b1, 1'b1, 8'h20, 16'h1234); step("pre20", 1'b1, 1'b0);
    set_cpu(1'b0, 1'b0, 8'h00, 16'h0000);
    set_dbg(1'b1, 1'b1, 8'h21, 16'h5678, 1'b0); step("pre21", 1'b0, 1'b1);
    set_dbg(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    set_cpu(1'b1, 1'b0, 8'h20, 16'h0000); step("mix_cpu", 1'b1, 1'b0);
    set_cpu(1'b0, 1'b0, 8'h00, 16'h0000);
    set_dbg(1'b1, 1'b0, 8'h21, 16'h0000, 1'b0); step("mix_dbg", 1'b0, 1'b1);
    set_cpu(1'b1, 1'b0, 8'h10, 16'h0000);
    set_dbg(1'b1, 1'b0, 8'h02, 16'h0000, 1'b0); step("alt_cpu", 1'b1, 1'b0);
    set_cpu(1'b0, 1'b0, 8'h00, 16'h0000); step("alt_dbg", 1'b0, 1'b1);
    set_dbg(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0); step("alt_end", 1'b0, 1'b0);

    // Reset while locked with a debug read outstanding
    set_dbg(1'b1, 1'b0, 8'h21, 16'h0000, 1'b1); step("rl_grant", 1'b0, 1'b1);
    ResetN = 1'b0;
    set_cpu(1'b1, 1'b1, 8'h50, 16'h1111); step("rl_reset", 1'b0, 1'b0);
    ResetN = 1'b1;
    set_cpu(1'b1, 1'b1, 8'h50, 16'h2222);
    set_dbg(1'b1, 1'b1, 8'h51, 16'h3333, 1'b0);
    chk_state("rl state", PRI_CPU);
    step("rl_after", 1'b1, 1'b0);
    set_cpu(1'b0, 1'b0, 8'h00, 16'h0000);
    set_dbg(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    step("idle_end", 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
